// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory responder.
package imem_pkg;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic {S_LOAD, S_SERVE} imem_state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction RAM: one synchronous write port, one synchronous read port.
module imem_array #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register only updates on a read, so it doubles as the response hold register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/imem_server.sv
// Instruction-memory responder: sequential program load, then 1-cycle PC-driven reads
// over a valid/ready handshake with flush.
module imem_server
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        loaded,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   input  logic        resp_ready,
   input  logic        flush
);

   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   imem_state_t   state;
   logic [AW-1:0] load_ptr;
   logic          addr_err;
   logic          accept;
   logic          ram_we;
   logic          ram_re;
   logic [31:0]   ram_rdata;

   // DEPTH is a power of two, so any set bit above the word index is out of range.
   assign addr_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
   assign load_ready = (state == S_LOAD);
   assign loaded     = (state == S_SERVE);
   assign req_ready  = (state == S_SERVE) && !flush && (!resp_valid || resp_ready);
   assign accept     = req_valid && req_ready;
   assign ram_we     = (state == S_LOAD) && load_valid;
   assign ram_re     = accept && !addr_err;
   assign resp_data  = resp_err ? NOP_INSN : ram_rdata;

   imem_array #(
      .DEPTH(DEPTH),
      .AW   (AW)
   ) u_array (
      .clk  (clk),
      .rst  (reset),
      .we   (ram_we),
      .waddr(load_ptr),
      .wdata(load_data),
      .re   (ram_re),
      .raddr(req_addr[AW+1:2]),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_LOAD;
         load_ptr   <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (load_valid) begin
                  if (load_last || load_ptr == LAST_PTR) begin
                     state <= S_SERVE;
                  end else begin
                     load_ptr <= load_ptr + 1'b1;
                  end
               end
            end
            S_SERVE: begin
               if (flush) begin
                  resp_valid <= 1'b0;
               end else if (accept) begin
                  resp_valid <= 1'b1;
                  resp_err   <= addr_err;
               end else if (resp_ready) begin
                  resp_valid <= 1'b0;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule
